// File: rtl/maze_explorer_param_if.sv
// Handshake bundle between the wall-sensor front end, the explorer and the motion executor.
// slave = explorer view, master = sensor/executor (or bench) view.
interface maze_explorer_param_if;
  logic       sense_valid;
  logic       left;
  logic       mid;
  logic       right;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move;

  modport slave (
    input  sense_valid, left, mid, right, move_ready,
    output move_valid, move
  );

  modport master (
    output sense_valid, left, mid, right, move_ready,
    input  move_valid, move
  );
endinterface

// File: rtl/maze_explorer_param.sv
// Grid maze explorer: tracks position/heading, keeps saturating per-cell visit counts and
// steers toward the least-visited open branch, issuing one move per sensor sample.
//
// state   | meaning
// S_SENSE | waiting for a wall sample; the accepting edge registers the decision
// S_ISSUE | move_valid high, holding move/target until the executor accepts
// S_DONE  | exit reached; all handshakes ignored until reset
module maze_explorer_param #(
  parameter int ROWS      = 9,
  parameter int COLS      = 9,
  parameter int START_IDX = 76,
  parameter int EXIT_IDX  = 4,
  parameter int START_DIR = 0,
  parameter int VCW       = 2,
  parameter int DCW       = 8,
  localparam int IDXW     = $clog2(ROWS*COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  maze_explorer_param_if.slave  bus,
  output logic [IDXW-1:0]       pos,
  output logic [1:0]            heading,
  output logic [DCW-1:0]        deadend_cnt,
  output logic                  done
);

  localparam int NCELL = ROWS*COLS;
  localparam logic signed [IDXW:0] COLS_S   = (IDXW+1)'(COLS);
  localparam logic signed [IDXW:0] ONE_S    = (IDXW+1)'(1);
  localparam logic signed [IDXW:0] NCELL_S  = (IDXW+1)'(NCELL);
  localparam logic [IDXW-1:0]      COLS_U   = IDXW'(COLS);
  localparam logic [IDXW-1:0]      COL_LAST = IDXW'(COLS-1);
  localparam logic [VCW-1:0]       VMAX     = '1;
  localparam logic [DCW-1:0]       DMAX     = '1;

  typedef enum logic [1:0] {S_SENSE, S_ISSUE, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_pos, r_target;
  logic [1:0]      r_heading, r_new_hd;
  logic [2:0]      r_move;
  logic [DCW-1:0]  r_dead;
  logic [VCW-1:0]  r_visit [NCELL];

  // Signed arithmetic so stepping off the north/south edge goes negative or past the end
  function automatic logic signed [IDXW:0] nbr_raw(input logic [IDXW-1:0] idx, input logic [1:0] dir);
    logic signed [IDXW:0] base;
    base = $signed({1'b0, idx});
    case (dir)
      2'd0:    nbr_raw = base - COLS_S;
      2'd1:    nbr_raw = base + ONE_S;
      2'd2:    nbr_raw = base + COLS_S;
      default: nbr_raw = base - ONE_S;
    endcase
  endfunction

  function automatic logic nbr_ok(input logic [IDXW-1:0] idx, input logic [1:0] dir);
    logic signed [IDXW:0] n;
    logic [IDXW-1:0]      col;
    logic                 ok;
    n   = nbr_raw(idx, dir);
    col = idx % COLS_U;
    case (dir)
      2'd1:    ok = (col != COL_LAST);
      2'd3:    ok = (col != '0);
      default: ok = 1'b1;
    endcase
    nbr_ok = ok && (n[IDXW] == 1'b0) && (n < NCELL_S);
  endfunction

  logic [IDXW-1:0] w_nidx [4];
  logic            w_nok  [4];
  logic [1:0]      w_dir_l, w_dir_s, w_dir_r, w_dir_b;
  logic            w_open_l, w_open_s, w_open_r;
  logic [IDXW-1:0] w_tgt_l, w_tgt_s, w_tgt_r;
  logic [VCW-1:0]  w_cnt_l, w_cnt_s, w_cnt_r, w_best;
  logic            w_any;
  logic [2:0]      w_pick_move;
  logic [IDXW-1:0] w_pick_tgt;
  logic [1:0]      w_pick_dir;

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      w_nidx[d] = IDXW'(nbr_raw(r_pos, 2'(d)));
      w_nok[d]  = nbr_ok(r_pos, 2'(d));
    end
  end

  assign w_dir_l  = r_heading - 2'd1;
  assign w_dir_s  = r_heading;
  assign w_dir_r  = r_heading + 2'd1;
  assign w_dir_b  = r_heading + 2'd2;
  assign w_tgt_l  = w_nidx[w_dir_l];
  assign w_tgt_s  = w_nidx[w_dir_s];
  assign w_tgt_r  = w_nidx[w_dir_r];
  assign w_open_l = !bus.left  && w_nok[w_dir_l];
  assign w_open_s = !bus.mid   && w_nok[w_dir_s];
  assign w_open_r = !bus.right && w_nok[w_dir_r];
  assign w_cnt_l  = r_visit[w_tgt_l];
  assign w_cnt_s  = r_visit[w_tgt_s];
  assign w_cnt_r  = r_visit[w_tgt_r];

  // Strict less-than keeps the left > straight > right tie priority
  always_comb begin
    w_pick_move = 3'd4;
    w_pick_tgt  = w_nidx[w_dir_b];
    w_pick_dir  = w_dir_b;
    w_best      = '1;
    w_any       = 1'b0;
    if (w_open_l) begin
      w_pick_move = 3'd2;
      w_pick_tgt  = w_tgt_l;
      w_pick_dir  = w_dir_l;
      w_best      = w_cnt_l;
      w_any       = 1'b1;
    end
    if (w_open_s && (!w_any || (w_cnt_s < w_best))) begin
      w_pick_move = 3'd1;
      w_pick_tgt  = w_tgt_s;
      w_pick_dir  = w_dir_s;
      w_best      = w_cnt_s;
      w_any       = 1'b1;
    end
    if (w_open_r && (!w_any || (w_cnt_r < w_best))) begin
      w_pick_move = 3'd3;
      w_pick_tgt  = w_tgt_r;
      w_pick_dir  = w_dir_r;
      w_best      = w_cnt_r;
      w_any       = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SENSE: if (bus.sense_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.move_ready)
                 w_state_nxt = (r_target == IDXW'(EXIT_IDX)) ? S_DONE : S_SENSE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_SENSE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SENSE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos     <= IDXW'(START_IDX);
      r_heading <= 2'(START_DIR);
      r_target  <= '0;
      r_new_hd  <= '0;
      r_move    <= '0;
      r_dead    <= '0;
      for (int i = 0; i < NCELL; i++) r_visit[i] <= '0;
    end else begin
      if (r_state == S_SENSE && bus.sense_valid) begin
        r_move   <= w_pick_move;
        r_target <= w_pick_tgt;
        r_new_hd <= w_pick_dir;
        if (r_visit[r_pos] != VMAX) r_visit[r_pos] <= r_visit[r_pos] + 1'b1;
        if (!w_any && r_dead != DMAX) r_dead <= r_dead + 1'b1;
      end
      if (r_state == S_ISSUE && bus.move_ready) begin
        r_pos     <= r_target;
        r_heading <= r_new_hd;
      end
    end
  end

  always_comb begin
    bus.move_valid = (r_state == S_ISSUE);
    bus.move       = (r_state == S_ISSUE) ? r_move : 3'd0;
    done           = (r_state == S_DONE);
  end

  assign pos         = r_pos;
  assign heading     = r_heading;
  assign deadend_cnt = r_dead;

endmodule
